serial_add_arb: RTL and testbench
=================================

SERIAL_ADD_ARB -- requirements
Module: serial_add_arb

Interface
REQ-001 Parameter: WIDTH, default 8, operand/sum width in bits (legal range 2..32).
REQ-002 Ports: CK  in  1  rising-edge clock.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 req0 / req1  in  1  level request from requester 0 / 1, held until matching ack.
REQ-005 a0, b0 / a1, b1  in  WIDTH  unsigned/two's-complement addends of requester 0 / 1.
REQ-006 ack0 / ack1  out  1  one-cycle pulse: operands of requester 0 / 1 captured.
REQ-007 busy  out  1  high while an addition is in progress (states RUN and DONE).
REQ-008 done  out  1  one-cycle pulse: sum, cout, ovf and owner valid.
REQ-009 owner  out  1  index of requester that owns the current/last result.
REQ-010 sum  out  WIDTH  result; cout  out  1  carry out; ovf  out  1  signed overflow.
REQ-011 One clock (CK); RST is asynchronous and active-high; all state is registered on CK.

Function
REQ-012 One shared single-bit full adder (s = a^b^c, c' = ab|ac|bc) with one carry flip-flop processes operands LSB first, one bit per cycle.
REQ-013 FSM states: IDLE, RUN, DONE; IDLE->RUN on an edge with req0|req1; RUN->DONE after WIDTH bit cycles; DONE->IDLE unconditionally after one cycle.
REQ-014 Capture edge in IDLE: granted a/b loaded into shift registers, carry cleared, bit counter cleared, owner updated, ack of the granted requester high for the following cycle only.
REQ-015 Arbitration round-robin: single request wins; both requesting -> grant the requester not served last; after reset "last served" = 1, so req0 wins the first tie.
REQ-016 Requests are sampled only in IDLE; requests during RUN/DONE are ignored, not stored; a request still high after its ack is treated as a new request.
REQ-017 RUN: each cycle one sum bit shifts into sum MSB and sum shifts right; after WIDTH cycles sum holds the full result and cout the final carry.
REQ-018 Latency: done high in the cycle starting WIDTH+1 edges after the capture edge; minimum gap between successive capture edges is WIDTH+2 cycles.
REQ-019 sum, cout, ovf, owner hold their values from done until the next capture edge; sum is undefined-but-stable (partial shift) during RUN and shall not be sampled then.
REQ-020 Arithmetic modulo 2^WIDTH; cout = bit WIDTH of a+b.

Reset
REQ-021 RST asserted (any time, including mid-RUN) immediately forces state IDLE, aborts the operation with no done pulse, last served = 1.
REQ-022 Reset values: ack0=ack1=0, busy=0, done=0, owner=0, sum=0, cout=0, ovf=0.
REQ-023 First capture is possible on the first CK rising edge after RST deasserts.

Configuration
REQ-024 Macro SERIAL_ADD_OVF_EN defined: ovf = (carry into MSB) XOR cout, registered with the final bit, valid with done.
REQ-025 Macro not defined: ovf port still present, tied to 0; no overflow logic synthesized.

Verification
REQ-026 WIDTH=8, req0 only, a0=0x0F, b0=0x01 -> ack0 pulse, done 9 edges after capture, sum=0x10, cout=0, owner=0.
REQ-027 req1 only, a1=0xFF, b1=0x01 -> sum=0x00, cout=1, owner=1, ovf=0 (both builds).
REQ-028 a0=0x7F, b0=0x01 -> sum=0x80, cout=0, ovf=1 with SERIAL_ADD_OVF_EN, ovf=0 without.
REQ-029 req0 and req1 held high continuously after reset -> owners at successive done pulses 0,1,0,1; ack pulses alternate; capture edges 10 cycles apart.
REQ-030 RST pulsed at 4th RUN cycle -> busy=0, sum=0, no done; next request after deassert completes correctly with the new operands.

Source files
------------

// File: rtl/serial_add_arb.sv
// Bit-serial adder shared by two requesters through a round-robin arbiter.
// Define SERIAL_ADD_OVF_EN to build the signed-overflow flag; otherwise ovf is tied low.
module serial_add_arb #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             CK,
   input  logic             RST,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             ack0,
   output logic             ack1,
   output logic             busy,
   output logic             done,
   output logic             owner,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d, cout_q, cout_d;
   logic             owner_q, owner_d, last_q, last_d;
   logic             ack0_q, ack0_d, ack1_q, ack1_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic             grant, s_bit, c_nxt;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   // Tie goes to the requester that was not served last
   assign grant = (req0 & req1) ? ~last_q : req1;
   assign s_bit = sa_q[0] ^ sb_q[0] ^ carry_q;
   assign c_nxt = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      owner_d = owner_q;
      last_d  = last_q;
      busy_d  = busy_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      done_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               state_d = RUN;
               sa_d    = grant ? a1 : a0;
               sb_d    = grant ? b1 : b0;
               carry_d = 1'b0;
               cnt_d   = '0;
               owner_d = grant;
               last_d  = grant;
               ack0_d  = ~grant;
               ack1_d  = grant;
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            sa_d    = sa_q >> 1;
            sb_d    = sb_q >> 1;
            sum_d   = {s_bit, sum_q[WIDTH-1:1]};
            carry_d = c_nxt;
            if (cnt_q == LAST) begin
               state_d = DONE;
               cout_d  = c_nxt;
`ifdef SERIAL_ADD_OVF_EN
               // carry_q here is the carry into the MSB
               ovf_d   = carry_q ^ c_nxt;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         busy_q  <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign ack0  = ack0_q;
   assign ack1  = ack1_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign owner = owner_q;
   assign sum   = sum_q;
   assign cout  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf   = ovf_q;
`else
   assign ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_arb.sv
// Directed bench for serial_add_arb (WIDTH=8): vector table, round-robin tie run, mid-RUN reset.
module tb_serial_add_arb;

   localparam int unsigned W = 8;

   logic         CK = 1'b0;
   logic         RST = 1'b1;
   logic         req0 = 1'b0, req1 = 1'b0;
   logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic         ack0, ack1, busy, done, owner, cout, ovf;
   logic [W-1:0] sum;

   int nchecks = 0;
   int nerrors = 0;

   serial_add_arb #(.WIDTH(W)) dut (
      .CK(CK), .RST(RST), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .ack0(ack0), .ack1(ack1), .busy(busy), .done(done), .owner(owner),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 CK = ~CK;

   typedef struct {
      logic         rsel;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
      logic         exp_ovf;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic ovf_exp(input logic v);
`ifdef SERIAL_ADD_OVF_EN
      return v;
`else
      return 1'b0;
`endif
   endfunction

   // One full transaction from an idle DUT; done must appear exactly W+1 edges after capture
   task automatic run_op(input logic rsel, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] es, input logic ec, input logic eo);
      int k;
      if (rsel) begin a1 = a; b1 = b; req1 = 1'b1; end
      else      begin a0 = a; b0 = b; req0 = 1'b1; end
      @(posedge CK); #1;
      req0 = 1'b0; req1 = 1'b0;
      chk("ack_granted", {31'd0, rsel ? ack1 : ack0}, 32'd1);
      chk("ack_other", {31'd0, rsel ? ack0 : ack1}, 32'd0);
      chk("busy_run", {31'd0, busy}, 32'd1);
      k = 0;
      for (int e = 1; e <= int'(W) + 4; e++) begin
         @(posedge CK); #1;
         if (ack0 | ack1) chk("ack_one_cycle", {30'd0, ack1, ack0}, 32'd0);
         if (done) begin k = e; break; end
      end
      chk("done_latency", k, W + 1);
      chk("sum", {24'd0, sum}, {24'd0, es});
      chk("cout", {31'd0, cout}, {31'd0, ec});
      chk("ovf", {31'd0, ovf}, {31'd0, ovf_exp(eo)});
      chk("owner", {31'd0, owner}, {31'd0, rsel});
      @(posedge CK); #1;
      chk("done_pulse", {31'd0, done}, 32'd0);
      chk("sum_hold", {24'd0, sum}, {24'd0, es});
   endtask

   initial begin
      int cap_e[4], cap_i[4], own[4];
      logic [W-1:0] dsum[4];
      int nc, nd, seen_done;

      vecs[0] = '{1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
      vecs[4] = '{1'b0, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0};
      vecs[5] = '{1'b1, 8'hC8, 8'h64, 8'h2C, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      vecs[7] = '{1'b1, 8'h40, 8'h40, 8'h80, 1'b0, 1'b1};

      #2;
      chk("rst_outputs", {20'd0, ack0, ack1, busy, done, owner, cout, ovf, 5'd0},
          32'd0);
      chk("rst_sum", {24'd0, sum}, 32'd0);
      repeat (2) @(posedge CK);
      #1 RST = 1'b0;
      @(posedge CK); #1;

      for (int i = 0; i < 8; i++)
         run_op(vecs[i].rsel, vecs[i].a, vecs[i].b, vecs[i].exp_sum, vecs[i].exp_cout,
                vecs[i].exp_ovf);

      // Both requesters held high from reset: alternate 0,1,0,1 with captures 10 edges apart
      RST = 1'b1;
      a0 = 8'h01; b0 = 8'h02; a1 = 8'h03; b1 = 8'h04;
      req0 = 1'b1; req1 = 1'b1;
      @(negedge CK);
      RST = 1'b0;
      nc = 0; nd = 0;
      for (int e = 0; e < 40; e++) begin
         @(posedge CK); #1;
         if ((ack0 | ack1) && nc < 4) begin cap_e[nc] = e; cap_i[nc] = int'(ack1); nc++; end
         if (done && nd < 4) begin own[nd] = int'(owner); dsum[nd] = sum; nd++; end
      end
      req0 = 1'b0; req1 = 1'b0;
      chk("tie_captures", nc, 4);
      chk("tie_dones", nd, 4);
      chk("tie_first_cap_edge", cap_e[0], 0);
      for (int i = 0; i < 4; i++) begin
         chk("tie_ack_idx", cap_i[i], i % 2);
         chk("tie_owner", own[i], i % 2);
         chk("tie_sum", {24'd0, dsum[i]}, (i % 2) ? 32'h07 : 32'h03);
         if (i > 0) chk("tie_cap_gap", cap_e[i] - cap_e[i-1], W + 2);
      end
      repeat (2) @(posedge CK); #1;

      // Reset asserted in the 4th RUN cycle aborts without a done pulse
      a0 = 8'h0F; b0 = 8'h01; req0 = 1'b1;
      @(posedge CK); #1;
      req0 = 1'b0;
      chk("abort_started", {31'd0, busy}, 32'd1);
      repeat (3) @(posedge CK);
      #1 RST = 1'b1;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_sum", {24'd0, sum}, 32'd0);
      chk("abort_flags", {28'd0, done, owner, cout, ack0}, 32'd0);
      @(posedge CK); #1;
      RST = 1'b0;
      seen_done = 0;
      for (int e = 0; e < 14; e++) begin
         @(posedge CK); #1;
         if (done | busy) seen_done = 1;
      end
      chk("abort_no_done", seen_done, 0);
      run_op(1'b1, 8'h22, 8'h11, 8'h33, 1'b0, 1'b0);
      run_op(1'b0, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
